// File: rtl/wbsamplefifo_pkg.sv
// Shared register map and bit positions for the Wishbone sample FIFO.
package wbsamplefifo_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_THRESH = 2'd3;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_UNF     = 3;
    localparam int ST_CNT_LSB = 8;

    localparam int CTRL_CLR        = 0;
    localparam int CTRL_CLR_STICKY = 1;
    localparam int CTRL_IE         = 2;

endpackage

// File: rtl/wbsamplefifo_sfifo.sv
// Single-clock FIFO with explicit count; read data is the head word, valid whenever not empty.
module wbsamplefifo_sfifo #(
    parameter int LGFIFO = 4,
    parameter int DW     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr,
    input  logic [DW-1:0]     wr_data,
    input  logic              rd,
    output logic [DW-1:0]     rd_data,
    output logic [LGFIFO:0]   count,
    output logic              full,
    output logic              empty
);

    localparam logic [LGFIFO:0] DEPTH = {1'b1, {LGFIFO{1'b0}}};

    logic [DW-1:0]     mem [2**LGFIFO];
    logic [LGFIFO-1:0] wr_ptr, rd_ptr;
    logic              do_wr, do_rd;

    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign do_wr   = wr & ~full;
    assign do_rd   = rd & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/wbsamplefifo.sv
// Wishbone pipelined slave buffering host samples in a FIFO with status/control registers.
// Optional WBSFIFO_ERR_EN: write-when-full / read-when-empty answer with o_wb_err.
module wbsamplefifo
    import wbsamplefifo_pkg::*;
#(
    parameter int LGFIFO = 4,
    parameter int DW     = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    input  logic          i_wb_we,
    input  logic [1:0]    i_wb_addr,
    input  logic [DW-1:0] i_wb_data,
    output logic          o_wb_ack,
    output logic          o_wb_stall,
    output logic          o_wb_err,
    output logic [DW-1:0] o_wb_data,
    output logic          o_int
);

    logic              accept, is_data;
    logic              wr_req, rd_req, bad_wr, bad_rd;
    logic              ctrl_wr, thresh_wr, fifo_clr;
    logic [DW-1:0]     fifo_rd_data, rdata, data_q;
    logic [LGFIFO:0]   count, thresh;
    logic              full, empty, ovf, unf, ie, ack_q;

    assign accept    = i_wb_cyc & i_wb_stb;
    assign is_data   = (i_wb_addr == ADDR_DATA);
    assign wr_req    = accept &  i_wb_we & is_data;
    assign rd_req    = accept & ~i_wb_we & is_data;
    assign bad_wr    = wr_req & full;
    assign bad_rd    = rd_req & empty;
    assign ctrl_wr   = accept & i_wb_we & (i_wb_addr == ADDR_CTRL);
    assign thresh_wr = accept & i_wb_we & (i_wb_addr == ADDR_THRESH);
    assign fifo_clr  = ctrl_wr & i_wb_data[CTRL_CLR];

    wbsamplefifo_sfifo #(.LGFIFO(LGFIFO), .DW(DW)) u_sfifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .clr     (fifo_clr),
        .wr      (wr_req),
        .wr_data (i_wb_data),
        .rd      (rd_req),
        .rd_data (fifo_rd_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        rdata = '0;
        case (i_wb_addr)
            ADDR_DATA:   if (!empty) rdata = fifo_rd_data;
            ADDR_STATUS: begin
                rdata[ST_EMPTY] = empty;
                rdata[ST_FULL]  = full;
                rdata[ST_OVF]   = ovf;
                rdata[ST_UNF]   = unf;
                rdata[ST_CNT_LSB +: LGFIFO+1] = count;
            end
            ADDR_CTRL:   rdata[CTRL_IE] = ie;
            default:     rdata[LGFIFO:0] = thresh;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ack_q  <= 1'b0;
            data_q <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            ie     <= 1'b0;
            thresh <= '0;
            o_int  <= 1'b0;
        end else begin
`ifdef WBSFIFO_ERR_EN
            ack_q  <= accept & ~(bad_wr | bad_rd);
`else
            ack_q  <= accept;
`endif
            data_q <= (accept && !i_wb_we) ? rdata : '0;
            if (ctrl_wr && i_wb_data[CTRL_CLR_STICKY]) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end else begin
                if (bad_wr) ovf <= 1'b1;
                if (bad_rd) unf <= 1'b1;
            end
            if (ctrl_wr)   ie     <= i_wb_data[CTRL_IE];
            if (thresh_wr) thresh <= i_wb_data[LGFIFO:0];
            o_int <= ie & (((thresh != '0) && (count >= thresh)) | ovf | unf);
        end
    end

`ifdef WBSFIFO_ERR_EN
    logic err_q;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) err_q <= 1'b0;
        else          err_q <= bad_wr | bad_rd;
    end
    assign o_wb_err = err_q & i_wb_cyc;
`else
    assign o_wb_err = 1'b0;
`endif

    // Dropping cyc in the response cycle abandons the reply, not the side effects.
    assign o_wb_ack   = ack_q & i_wb_cyc;
    assign o_wb_data  = o_wb_ack ? data_q : '0;
    assign o_wb_stall = 1'b0;

endmodule

// File: tb/tb_wbsamplefifo.sv
// Directed self-checking bench for wbsamplefifo.
module tb_wbsamplefifo;

`ifdef WBSFIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = '0;
    logic        ack, stall, err, irq;
    logic [31:0] rdat;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wbsamplefifo dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wb_cyc   (cyc),
        .i_wb_stb   (stb),
        .i_wb_we    (we),
        .i_wb_addr  (addr),
        .i_wb_data  (wdata),
        .o_wb_ack   (ack),
        .o_wb_stall (stall),
        .o_wb_err   (err),
        .o_wb_data  (rdat),
        .o_int      (irq)
    );

    // Entered at #1 after a rising edge; returns at #1 after the accept edge with the reply sampled.
    task automatic xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                        output logic r_ack, output logic r_err, output logic [31:0] r_dat);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        stb = 1'b0;
        r_ack = ack; r_err = err; r_dat = rdat;
    endtask

    task automatic idle();
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic a, e; logic [31:0] d;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ack !== 1'b0 || err !== 1'b0 || rdat !== 32'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs ack=%b err=%b data=%h int=%b want all 0", ack, err, rdat, irq);
        end
        rst_n = 1'b1;
        xfer(1'b0, 2'd1, 32'h0, a, e, d);
        checks++;
        if (a !== 1'b1 || e !== 1'b0 || d !== 32'h1) begin
            failures++;
            $display("FAIL reset_status ack=%b err=%b data=%h want ack=1 data=00000001", a, e, d);
        end
        xfer(1'b0, 2'd2, 32'h0, a, e, d);
        checks++;
        if (a !== 1'b1 || d !== 32'h0) begin
            failures++;
            $display("FAIL reset_ctrl ack=%b data=%h want ack=1 data=0", a, d);
        end
        xfer(1'b0, 2'd3, 32'h0, a, e, d);
        checks++;
        if (a !== 1'b1 || d !== 32'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_thresh ack=%b data=%h int=%b want ack=1 data=0 int=0", a, d, irq);
        end
        idle();
        checks++;
        if (ack !== 1'b0 || rdat !== 32'h0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_ack ack=%b data=%h stall=%b want 0", ack, rdat, stall);
        end
    endtask

    task automatic test_back_to_back();
        logic a, e; logic [31:0] d;
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            xfer(1'b1, 2'd0, vals[i], a, e, d);
            checks++;
            if (a !== 1'b1 || e !== 1'b0) begin
                failures++;
                $display("FAIL b2b_write%0d ack=%b err=%b want ack=1 err=0", i, a, e);
            end
        end
        for (int i = 0; i < 3; i++) begin
            xfer(1'b0, 2'd0, 32'h0, a, e, d);
            checks++;
            if (a !== 1'b1 || d !== vals[i]) begin
                failures++;
                $display("FAIL b2b_read%0d ack=%b data=%h want ack=1 data=%h", i, a, d, vals[i]);
            end
        end
        xfer(1'b0, 2'd1, 32'h0, a, e, d);
        checks++;
        if (a !== 1'b1 || d !== 32'h1) begin
            failures++;
            $display("FAIL b2b_status data=%h want 00000001", d);
        end
        idle();
    endtask

    task automatic test_overflow();
        logic a, e; logic [31:0] d;
        for (int i = 0; i < 16; i++) xfer(1'b1, 2'd0, 32'h100 + i, a, e, d);
        xfer(1'b1, 2'd0, 32'hDEAD, a, e, d);
        checks++;
        if (a !== !ERR_EN || e !== ERR_EN) begin
            failures++;
            $display("FAIL overflow_resp ack=%b err=%b want ack=%b err=%b", a, e, !ERR_EN, ERR_EN);
        end
        xfer(1'b0, 2'd1, 32'h0, a, e, d);
        checks++;
        if (d !== 32'h1006) begin
            failures++;
            $display("FAIL overflow_status data=%h want 00001006", d);
        end
        for (int i = 0; i < 16; i++) begin
            xfer(1'b0, 2'd0, 32'h0, a, e, d);
            checks++;
            if (a !== 1'b1 || d !== 32'h100 + i) begin
                failures++;
                $display("FAIL overflow_drain%0d ack=%b data=%h want %h", i, a, d, 32'h100 + i);
            end
        end
        xfer(1'b0, 2'd1, 32'h0, a, e, d);
        checks++;
        if (d !== 32'h5) begin
            failures++;
            $display("FAIL overflow_sticky data=%h want 00000005", d);
        end
        xfer(1'b1, 2'd2, 32'h2, a, e, d);
        xfer(1'b0, 2'd1, 32'h0, a, e, d);
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("FAIL overflow_clear data=%h want 00000001", d);
        end
        idle();
    endtask

    task automatic test_interrupt();
        logic a, e; logic [31:0] d;
        xfer(1'b1, 2'd2, 32'h4, a, e, d);
        xfer(1'b1, 2'd3, 32'h3, a, e, d);
        xfer(1'b0, 2'd3, 32'h0, a, e, d);
        checks++;
        if (d !== 32'h3) begin
            failures++;
            $display("FAIL thresh_read data=%h want 00000003", d);
        end
        for (int i = 0; i < 3; i++) xfer(1'b1, 2'd0, 32'hA0 + i, a, e, d);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL int_early int=%b want 0 in third-ack cycle", irq);
        end
        cyc = 1'b0; @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL int_rise int=%b want 1", irq);
        end
        xfer(1'b0, 2'd0, 32'h0, a, e, d);
        checks++;
        if (d !== 32'hA0 || irq !== 1'b1) begin
            failures++;
            $display("FAIL int_pop data=%h int=%b want A0 int=1", d, irq);
        end
        cyc = 1'b0; @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL int_fall int=%b want 0", irq);
        end
        // Clear FIFO while keeping the interrupt enabled.
        xfer(1'b1, 2'd2, 32'h5, a, e, d);
        xfer(1'b0, 2'd2, 32'h0, a, e, d);
        checks++;
        if (d !== 32'h4) begin
            failures++;
            $display("FAIL ctrl_selfclear data=%h want 00000004", d);
        end
        xfer(1'b0, 2'd1, 32'h0, a, e, d);
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("FAIL clr_fifo_status data=%h want 00000001", d);
        end
        idle();
    endtask

    task automatic test_underflow();
        logic a, e; logic [31:0] d;
        xfer(1'b0, 2'd0, 32'h0, a, e, d);
        checks++;
        if (a !== !ERR_EN || e !== ERR_EN || rdat !== 32'h0 || d !== 32'h0) begin
            failures++;
            $display("FAIL underflow_resp ack=%b err=%b data=%h want ack=%b err=%b data=0", a, e, d, !ERR_EN, ERR_EN);
        end
        xfer(1'b0, 2'd1, 32'h0, a, e, d);
        checks++;
        if (d !== 32'h9 || irq !== 1'b1) begin
            failures++;
            $display("FAIL underflow_status data=%h int=%b want 00000009 int=1", d, irq);
        end
        xfer(1'b1, 2'd2, 32'h2, a, e, d);
        xfer(1'b0, 2'd1, 32'h0, a, e, d);
        checks++;
        if (d !== 32'h1 || irq !== 1'b0) begin
            failures++;
            $display("FAIL underflow_clear data=%h int=%b want 00000001 int=0", d, irq);
        end
        idle();
    endtask

    task automatic test_cyc_drop();
        logic a, e; logic [31:0] d;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 2'd0; wdata = 32'h77;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        #1;
        checks++;
        if (ack !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL cycdrop_ack ack=%b err=%b want 0", ack, err);
        end
        @(posedge clk); #1;
        xfer(1'b0, 2'd1, 32'h0, a, e, d);
        checks++;
        if (d !== 32'h100) begin
            failures++;
            $display("FAIL cycdrop_count data=%h want 00000100", d);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        logic a, e; logic [31:0] d;
        xfer(1'b1, 2'd0, 32'h1, a, e, d);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 2'd0; wdata = 32'h2;
        rst_n = 1'b0;
        @(posedge clk); #1;
        stb = 1'b0;
        checks++;
        if (ack !== 1'b0) begin
            failures++;
            $display("FAIL midreset_ack ack=%b want 0", ack);
        end
        rst_n = 1'b1;
        xfer(1'b0, 2'd1, 32'h0, a, e, d);
        checks++;
        if (a !== 1'b1 || d !== 32'h1) begin
            failures++;
            $display("FAIL midreset_status ack=%b data=%h want ack=1 data=00000001", a, d);
        end
        idle();
    endtask

    initial begin
        #1;
        test_reset();
        test_back_to_back();
        test_overflow();
        test_interrupt();
        test_underflow();
        test_cyc_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
